branch_resolve_unit: RTL

Next-generation branch comparator for the in-order pipeline. It resolves conditional branches against operands forwarded from NUM_FWD later pipeline stages (index 0 = youngest, highest priority) and supports six compare modes. It stalls while a needed forwarded value is not yet available (load/cache miss in flight). It registers the decision for the fetch/PC logic and flags operands stuck beyond a timeout.

---
 rtl/branch_pkg.sv | 21 ++
 rtl/fwd_select.sv | 37 +++
 rtl/branch_resolve_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared types for the branch resolve stage.
// Compare-mode and FSM encodings.
package branch_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLT  = 3'd2,
    BGE  = 3'd3,
    BLTU = 3'd4,
    BGEU = 3'd5
  } br_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } br_state_e;

  localparam int BR_OP_LAST = 5;

endpackage

// File: rtl/fwd_select.sv
// Priority operand forwarding for one source register.
// Index 0 is the youngest stage and wins over all others.
module fwd_select
  import branch_pkg::*;
#(
  parameter int NUM_BITS      = 32,
  parameter int NUM_FWD       = 2,
  parameter int REG_ADDR_BITS = 5
) (
  input  logic [REG_ADDR_BITS-1:0]         rs_addr,
  input  logic [NUM_BITS-1:0]              rf_data,
  input  logic [NUM_FWD-1:0]               fwd_valid,
  input  logic [NUM_FWD-1:0]               fwd_ready,
  input  logic [NUM_FWD*REG_ADDR_BITS-1:0] fwd_addr,
  input  logic [NUM_FWD*NUM_BITS-1:0]      fwd_data,
  output logic [NUM_BITS-1:0]              operand,
  output logic                             pending
);

  logic rs_nz;

  assign rs_nz = (rs_addr != '0);

  // Scan oldest to youngest so the youngest match is applied last.
  always_comb begin
    operand = rf_data;
    pending = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && rs_nz &&
          fwd_addr[i*REG_ADDR_BITS +: REG_ADDR_BITS] == rs_addr) begin
        operand = fwd_data[i*NUM_BITS +: NUM_BITS];
        pending = !fwd_ready[i];
      end
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch comparator with forwarding, load stall and timeout.
// Decision is registered one cycle after operands are final.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int NUM_BITS      = 32,
  parameter int NUM_FWD       = 2,
  parameter int REG_ADDR_BITS = 5,
  parameter int MAX_WAIT      = 15
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             br_valid,
  input  logic [2:0]                       br_op,
  input  logic [REG_ADDR_BITS-1:0]         rs1_addr,
  input  logic [REG_ADDR_BITS-1:0]         rs2_addr,
  input  logic [NUM_BITS-1:0]              data1,
  input  logic [NUM_BITS-1:0]              data2,
  input  logic                             flush,
  input  logic [NUM_FWD-1:0]               fwd_valid,
  input  logic [NUM_FWD-1:0]               fwd_ready,
  input  logic [NUM_FWD*REG_ADDR_BITS-1:0] fwd_addr,
  input  logic [NUM_FWD*NUM_BITS-1:0]      fwd_data,
  output logic                             stall,
  output logic                             resolve_valid,
  output logic                             resolve_taken,
  output logic                             illegal_op,
  output logic [$clog2(MAX_WAIT+1)-1:0]    wait_cycles,
  output logic                             timeout_err
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [NUM_BITS-1:0] op1;
  logic [NUM_BITS-1:0] op2;
  logic                pend1;
  logic                pend2;
  logic                go;
  logic                pend;
  logic                taken_c;
  logic                illegal_c;
  br_op_e              op_e;

  br_state_e           state;
  br_state_e           state_d;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_d;
  logic [CW-1:0]       cnt_inc;
  logic                fire;
  logic                set_to;

  fwd_select #(
    .NUM_BITS      (NUM_BITS),
    .NUM_FWD       (NUM_FWD),
    .REG_ADDR_BITS (REG_ADDR_BITS)
  ) u_fwd1 (
    .rs_addr   (rs1_addr),
    .rf_data   (data1),
    .fwd_valid (fwd_valid),
    .fwd_ready (fwd_ready),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data),
    .operand   (op1),
    .pending   (pend1)
  );

  fwd_select #(
    .NUM_BITS      (NUM_BITS),
    .NUM_FWD       (NUM_FWD),
    .REG_ADDR_BITS (REG_ADDR_BITS)
  ) u_fwd2 (
    .rs_addr   (rs2_addr),
    .rf_data   (data2),
    .fwd_valid (fwd_valid),
    .fwd_ready (fwd_ready),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data),
    .operand   (op2),
    .pending   (pend2)
  );

  assign go        = br_valid & ~flush;
  assign pend      = go & (pend1 | pend2);
  assign stall     = pend;
  assign op_e      = br_op_e'(br_op);
  assign illegal_c = (br_op > 3'(BR_OP_LAST));
  assign cnt_inc   = (cnt == MAX_CNT) ? cnt : cnt + ONE;

  always_comb begin
    taken_c = 1'b0;
    unique case (op_e)
      BEQ:     taken_c = (op1 == op2);
      BNE:     taken_c = (op1 != op2);
      BLT:     taken_c = ($signed(op1) <  $signed(op2));
      BGE:     taken_c = ($signed(op1) >= $signed(op2));
      BLTU:    taken_c = (op1 <  op2);
      BGEU:    taken_c = (op1 >= op2);
      default: taken_c = 1'b0;
    endcase
  end

  // cnt is kept at zero in IDLE so it doubles as wait_cycles.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    fire    = 1'b0;
    set_to  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (go && !pend) begin
          fire = 1'b1;
        end else if (pend) begin
          state_d = WAIT;
          cnt_d   = ONE;
          set_to  = (ONE == MAX_CNT);
        end
      end
      WAIT: begin
        if (flush || !br_valid) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!pend) begin
          fire    = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_inc;
          set_to = (cnt_inc == MAX_CNT);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      resolve_valid <= 1'b0;
      resolve_taken <= 1'b0;
      illegal_op    <= 1'b0;
      wait_cycles   <= '0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      resolve_valid <= fire;
      resolve_taken <= fire & taken_c & ~illegal_c;
      illegal_op    <= fire & illegal_c;
      if (fire) begin
        wait_cycles <= cnt;
      end
      if (set_to) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule
